// File: rtl/rv64_pkg.sv
// Shared RV64I decode definitions: base opcodes, the canonical NOP and
// the immediate-format classification used by the decode stage.
package rv64_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h00000013;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_type_e;

    // Immediate format selected purely by the major opcode.
    function automatic imm_type_e imm_type_of(input logic [6:0] opc);
        imm_type_e t;
        case (opc)
            OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32,
            OPC_JALR, OPC_SYSTEM:            t = IMM_I;
            OPC_STORE:                       t = IMM_S;
            OPC_BRANCH:                      t = IMM_B;
            OPC_LUI, OPC_AUIPC:              t = IMM_U;
            OPC_JAL:                         t = IMM_J;
            default:                         t = IMM_NONE;
        endcase
        return t;
    endfunction

    // True for every major opcode of the RV64I base set.
    function automatic logic opc_legal(input logic [6:0] opc);
        logic ok;
        case (opc)
            OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_OP_IMM_32,
            OPC_STORE, OPC_OP, OPC_LUI, OPC_OP_32, OPC_BRANCH, OPC_JALR,
            OPC_JAL, OPC_SYSTEM:             ok = 1'b1;
            default:                         ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/id_imm_gen.sv
// Immediate generator: classifies the instruction format from its opcode and
// produces the sign-extended XLEN immediate. Purely combinational.
module id_imm_gen
    import rv64_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     inst_i,
    output imm_type_e       imm_type_o,
    output logic [XLEN-1:0] imm_o
);

    logic [31:0] imm32;

    // Assemble the 32-bit immediate for the format, then sign-extend to XLEN.
    always_comb begin
        imm_type_o = imm_type_of(inst_i[6:0]);
        imm32      = 32'h0;
        case (imm_type_o)
            IMM_I: imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
            IMM_S: imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            IMM_B: imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                            inst_i[30:25], inst_i[11:8], 1'b0};
            IMM_U: imm32 = {inst_i[31:12], 12'h000};
            IMM_J: imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                            inst_i[20], inst_i[30:21], 1'b0};
            default: imm32 = 32'h0;
        endcase
        imm_o = {{(XLEN-32){imm32[31]}}, imm32};
    end

endmodule

// File: rtl/id_stage.sv
// IF/ID pipeline register plus RV64I decode. Holds on a load-use hazard,
// squashes to a bubble on a taken jump/branch, and raises the stall that
// freezes the fetch PC.
module id_stage
    import rv64_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] if_pc_i,
    input  logic [31:0]     if_inst_i,
    input  logic            flush_i,
    input  logic            ex_mem_read_i,
    input  logic [4:0]      ex_rd_i,
    output logic            stall_o,
    output logic            id_valid_o,
    output logic [XLEN-1:0] id_pc_o,
    output logic [31:0]     id_inst_o,
    output logic [4:0]      id_rs1_o,
    output logic [4:0]      id_rs2_o,
    output logic [4:0]      id_rd_o,
    output logic [XLEN-1:0] id_imm_o,
    output logic            id_rs1_use_o,
    output logic            id_rs2_use_o,
    output logic            id_illegal_o
);

    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     inst_q;

    logic [6:0]      opc;
    imm_type_e       imm_type;
    logic            legal;
    logic            rs1_use_d;
    logic            rs2_use_d;
    logic            hazard_rs1;
    logic            hazard_rs2;

    // Pipeline register: reset beats flush, flush beats stall, stall beats load.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
        end else if (flush_i) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= NOP_INST;
        end else if (!stall_o) begin
            valid_q <= 1'b1;
            pc_q    <= if_pc_i;
            inst_q  <= if_inst_i;
        end
    end

    id_imm_gen #(
        .XLEN       (XLEN)
    ) u_imm_gen (
        .inst_i     (inst_q),
        .imm_type_o (imm_type),
        .imm_o      (id_imm_o)
    );

    // Operand-usage and legality decode; a bubble reports no usage so it
    // can never create a hazard.
    always_comb begin
        opc       = inst_q[6:0];
        legal     = opc_legal(opc);
        rs1_use_d = 1'b0;
        rs2_use_d = 1'b0;
        if (valid_q && legal) begin
            rs1_use_d = !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
            rs2_use_d = (opc == OPC_STORE) || (opc == OPC_BRANCH) ||
                        (opc == OPC_OP)    || (opc == OPC_OP_32);
        end
    end

    // Load-use hazard: the load in EX writes a register this instruction reads.
    // x0 is never a real dependency.
    always_comb begin
        hazard_rs1 = rs1_use_d && (ex_rd_i == inst_q[19:15]);
        hazard_rs2 = rs2_use_d && (ex_rd_i == inst_q[24:20]);
        stall_o    = valid_q && ex_mem_read_i && (ex_rd_i != 5'd0) &&
                     (hazard_rs1 || hazard_rs2);
    end

    assign id_valid_o   = valid_q;
    assign id_pc_o      = pc_q;
    assign id_inst_o    = inst_q;
    assign id_rs1_o     = inst_q[19:15];
    assign id_rs2_o     = inst_q[24:20];
    assign id_rd_o      = inst_q[11:7];
    assign id_rs1_use_o = rs1_use_d;
    assign id_rs2_use_o = rs2_use_d;
    assign id_illegal_o = valid_q && !legal;

    // Immediate format is consumed only inside the generator here.
    logic unused_imm_type;
    assign unused_imm_type = ^imm_type;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: a decode vector table plus hand-written
// sequences for reset, flush, stall hold and their interactions.
module tb_id_stage;

    localparam int          XLEN   = 64;
    localparam logic [63:0] RST_PC = 64'h0000_0000_0000_1000;
    localparam logic [31:0] NOP    = 32'h00000013;

    logic            clk = 1'b0;
    logic            rst;
    logic [XLEN-1:0] if_pc_i;
    logic [31:0]     if_inst_i;
    logic            flush_i;
    logic            ex_mem_read_i;
    logic [4:0]      ex_rd_i;
    logic            stall_o;
    logic            id_valid_o;
    logic [XLEN-1:0] id_pc_o;
    logic [31:0]     id_inst_o;
    logic [4:0]      id_rs1_o;
    logic [4:0]      id_rs2_o;
    logic [4:0]      id_rd_o;
    logic [XLEN-1:0] id_imm_o;
    logic            id_rs1_use_o;
    logic            id_rs2_use_o;
    logic            id_illegal_o;

    int tests;
    int fails;

    always #5 clk = ~clk;

    id_stage #(
        .XLEN     (XLEN),
        .RESET_PC (RST_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_pc_i       (if_pc_i),
        .if_inst_i     (if_inst_i),
        .flush_i       (flush_i),
        .ex_mem_read_i (ex_mem_read_i),
        .ex_rd_i       (ex_rd_i),
        .stall_o       (stall_o),
        .id_valid_o    (id_valid_o),
        .id_pc_o       (id_pc_o),
        .id_inst_o     (id_inst_o),
        .id_rs1_o      (id_rs1_o),
        .id_rs2_o      (id_rs2_o),
        .id_rd_o       (id_rd_o),
        .id_imm_o      (id_imm_o),
        .id_rs1_use_o  (id_rs1_use_o),
        .id_rs2_use_o  (id_rs2_use_o),
        .id_illegal_o  (id_illegal_o)
    );

    typedef struct {
        logic [31:0] inst;
        logic [4:0]  ex_rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] imm;
        logic        rs1u;
        logic        rs2u;
        logic        ill;
        logic        stall;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present a fetch instruction with no EX load, then let one edge capture it.
    task automatic load_inst(input logic [63:0] pc, input logic [31:0] inst);
        @(negedge clk);
        flush_i       = 1'b0;
        ex_mem_read_i = 1'b0;
        ex_rd_i       = 5'd0;
        if_pc_i       = pc;
        if_inst_i     = inst;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1; flush_i = 1'b0; ex_mem_read_i = 1'b0; ex_rd_i = 5'd0;
        if_pc_i = 64'h0; if_inst_i = NOP;

        //        inst          exrd  rs1   rs2   rd    imm                     r1u   r2u   ill   stall
        vecs[0]  = '{32'h00500093, 5'd5,  5'd0, 5'd5, 5'd1, 64'h5,                 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{32'h00208133, 5'd1,  5'd1, 5'd2, 5'd2, 64'h0,                 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{32'h00208133, 5'd2,  5'd1, 5'd2, 5'd2, 64'h0,                 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{32'h00208133, 5'd3,  5'd1, 5'd2, 5'd2, 64'h0,                 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{32'hfe000ee3, 5'd0,  5'd0, 5'd0, 5'd29, 64'hFFFFFFFFFFFFFFFC, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{32'h800000ef, 5'd1,  5'd0, 5'd0, 5'd1, 64'hFFFFFFFFFFF00000,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{32'h800002b7, 5'd5,  5'd0, 5'd0, 5'd5, 64'hFFFFFFFF80000000,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{32'h0000807f, 5'd1,  5'd1, 5'd0, 5'd0, 64'h0,                 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{32'h0000007f, 5'd0,  5'd0, 5'd0, 5'd0, 64'h0,                 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{32'h0020A423, 5'd2,  5'd1, 5'd2, 5'd8, 64'h8,                 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{32'hFF80B183, 5'd24, 5'd1, 5'd24, 5'd3, 64'hFFFFFFFFFFFFFFF8, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{32'h00001217, 5'd4,  5'd0, 5'd0, 5'd4, 64'h1000,              1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{32'h0ff0000f, 5'd31, 5'd0, 5'd31, 5'd0, 64'h0,                1'b1, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{32'h0010809b, 5'd1,  5'd1, 5'd1, 5'd1, 64'h1,                 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{32'h00500093, 5'd0,  5'd0, 5'd5, 5'd1, 64'h5,                 1'b1, 1'b0, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {127'h0, id_valid_o}, 128'h0);
        check("rst_pc",    {64'h0, id_pc_o}, {64'h0, RST_PC});
        check("rst_inst",  {96'h0, id_inst_o}, {96'h0, NOP});
        check("rst_stall", {127'h0, stall_o}, 128'h0);
        check("rst_use",   {125'h0, id_rs1_use_o, id_rs2_use_o, id_illegal_o}, 128'h0);
        @(negedge clk);
        rst = 1'b0;

        // Decode vector table: load, then present a load in EX and check
        for (int i = 0; i < 15; i++) begin
            load_inst(64'h80000000 + 64'(i * 4), vecs[i].inst);
            ex_mem_read_i = 1'b1;
            ex_rd_i       = vecs[i].ex_rd;
            #1;
            check($sformatf("vec%0d_ctl", i), {126'h0, id_valid_o, id_illegal_o},
                  {126'h0, 1'b1, vecs[i].ill});
            check($sformatf("vec%0d_pc", i), {64'h0, id_pc_o}, {64'h0, 64'h80000000 + 64'(i * 4)});
            check($sformatf("vec%0d_dec", i),
                  {45'h0, id_rs1_o, id_rs2_o, id_rd_o, id_imm_o, id_rs1_use_o, id_rs2_use_o, stall_o},
                  {45'h0, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].imm,
                   vecs[i].rs1u, vecs[i].rs2u, vecs[i].stall});
            ex_mem_read_i = 1'b0;
        end

        // Stall holds PC and instruction across an edge
        load_inst(64'h80000100, 32'h00208133);
        @(negedge clk);
        if_pc_i = 64'h80000104; if_inst_i = 32'h00500093;
        ex_mem_read_i = 1'b1; ex_rd_i = 5'd1;
        #1;
        check("hold_stall", {127'h0, stall_o}, {127'h0, 1'b1});
        @(posedge clk);
        #1;
        check("hold_pc",   {64'h0, id_pc_o}, {64'h0, 64'h80000100});
        check("hold_inst", {96'h0, id_inst_o}, {96'h0, 32'h00208133});
        check("hold_valid", {127'h0, id_valid_o}, {127'h0, 1'b1});
        // Load moves on, bubble in EX: stall releases and fetch is taken
        @(negedge clk);
        ex_mem_read_i = 1'b0;
        #1;
        check("release_stall", {127'h0, stall_o}, 128'h0);
        @(posedge clk);
        #1;
        check("release_load", {32'h0, id_pc_o, id_inst_o}, {32'h0, 64'h80000104, 32'h00500093});

        // Plain flush with a valid instruction at fetch
        @(negedge clk);
        flush_i = 1'b1; if_pc_i = 64'h80000200; if_inst_i = 32'h00208133;
        @(posedge clk);
        #1;
        check("flush_valid", {127'h0, id_valid_o}, 128'h0);
        check("flush_inst",  {96'h0, id_inst_o}, {96'h0, NOP});
        check("flush_pc",    {64'h0, id_pc_o}, 128'h0);
        check("flush_stall", {127'h0, stall_o}, 128'h0);

        // Flush and stall together: flush wins
        load_inst(64'h80000300, 32'h00208133);
        @(negedge clk);
        ex_mem_read_i = 1'b1; ex_rd_i = 5'd2; flush_i = 1'b1;
        #1;
        check("fs_stall_seen", {127'h0, stall_o}, {127'h0, 1'b1});
        @(posedge clk);
        #1;
        check("fs_squash", {95'h0, id_valid_o, id_inst_o}, {95'h0, 1'b0, NOP});
        check("fs_stall_after", {127'h0, stall_o}, 128'h0);

        // Reset during a stall
        load_inst(64'h80000400, 32'h00208133);
        @(negedge clk);
        ex_mem_read_i = 1'b1; ex_rd_i = 5'd1;
        #1;
        check("rs_stall_seen", {127'h0, stall_o}, {127'h0, 1'b1});
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rs_valid", {127'h0, id_valid_o}, 128'h0);
        check("rs_pc",    {64'h0, id_pc_o}, {64'h0, RST_PC});
        check("rs_stall", {127'h0, stall_o}, 128'h0);
        @(negedge clk);
        rst = 1'b0; ex_mem_read_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Safety net against a hung run
    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
